spi_slave: RTL

Configurable SPI slave (peripheral) controller: the responder end of the team's SPI master link. It oversamples the external SCLK/SS_N/MOSI pins with the system clock, shifts one DATA_W-bit word in from MOSI and one out on MISO per transaction, and raises an IRQ with the received word. It sits between the SPI pins of an FPGA acting as a peripheral and the local register/control logic. Mode (CPOL, CPHA, DORD) is selected by signals, matching the master's mode options.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_sync.sv | 32 +++
 rtl/spi_slave.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM encoding, synchronizer depth and mode-bit meanings
// common to the SPI master and slave.
package spi_pkg;

    localparam int unsigned SyncStages = 2;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StShift = 1'b1;

    localparam logic CpolIdleLow  = 1'b0;
    localparam logic CpolIdleHigh = 1'b1;
    localparam logic CphaLeading  = 1'b0;
    localparam logic CphaTrailing = 1'b1;
    localparam logic DordMsbFirst = 1'b0;
    localparam logic DordLsbFirst = 1'b1;

    typedef struct packed {
        logic sclk;
        logic ss_n;
        logic mosi;
    } spi_pins_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for asynchronous pin inputs; width and depth are parameters.
module spi_sync
    import spi_pkg::*;
#(
    parameter int unsigned      Width    = 1,
    parameter int unsigned      Stages   = SyncStages,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] sync_q [Stages];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Stages; i++) begin
                sync_q[i] <= ResetVal;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < Stages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/spi_slave.sv
// SPI slave: oversampled pins, one DATA_W-bit word in/out per SS window, IRQ on receive.
// Optional SPI_SLAVE_OVERRUN_EN adds ovr_o, flagging a word completed while irq_o was pending.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] tx_i,
    output logic [DATA_W-1:0] rx_o,
    output logic              busy_o,
    output logic              irq_o,
    input  logic              ack_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              dord_i,
    input  logic              sclk_i,
    input  logic              ss_n_i,
    input  logic              mosi_i,
`ifdef SPI_SLAVE_OVERRUN_EN
    output logic              ovr_o,
`endif
    output logic              miso_o,
    output logic              miso_en_o
);

    localparam int unsigned CntW = $clog2(DATA_W);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

    logic [2:0] pins_raw;
    spi_pins_t  pins;

    spi_sync #(
        .Width    (3),
        .Stages   (SyncStages),
        .ResetVal (3'b000)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   ({sclk_i, ss_n_i, mosi_i}),
        .q_o   (pins_raw)
    );

    assign pins = pins_raw;

    // ss_n edge register resets low so a select already active at reset is never
    // mistaken for a fresh falling edge.
    logic sclk_q, ss_n_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_q <= 1'b0;
            ss_n_q <= 1'b0;
        end else begin
            sclk_q <= pins.sclk;
            ss_n_q <= pins.ss_n;
        end
    end

    logic sck, sck_prev, lead_edge, trail_edge, ss_fall, ss_rise;
    logic sample_edge, shift_edge;

    assign sck         = pins.sclk ^ cpol_i;
    assign sck_prev    = sclk_q ^ cpol_i;
    assign lead_edge   = sck & ~sck_prev;
    assign trail_edge  = ~sck & sck_prev;
    assign ss_fall     = ~pins.ss_n & ss_n_q;
    assign ss_rise     = pins.ss_n & ~ss_n_q;
    assign sample_edge = (cpha_i == CphaTrailing) ? trail_edge : lead_edge;
    assign shift_edge  = (cpha_i == CphaTrailing) ? lead_edge : trail_edge;

    logic [0:0]        state_q, state_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic              irq_q, irq_d;
    logic              reload_q, reload_d;
    logic              word_done;
    logic              miso_q, miso_en_q;
    logic [DATA_W-1:0] rx_shifted, tx_shifted;

    always_comb begin
        if (dord_i == DordLsbFirst) begin
            rx_shifted = {pins.mosi, rx_sr_q[DATA_W-1:1]};
            tx_shifted = {1'b0, tx_sr_q[DATA_W-1:1]};
        end else begin
            rx_shifted = {rx_sr_q[DATA_W-2:0], pins.mosi};
            tx_shifted = {tx_sr_q[DATA_W-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        reload_d  = reload_q;
        word_done = 1'b0;

        unique case (state_q)
            StIdle: begin
                bit_cnt_d = '0;
                reload_d  = 1'b0;
                if (ss_fall) begin
                    tx_sr_d = tx_i;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (ss_rise) begin
                    state_d   = StIdle;
                    bit_cnt_d = '0;
                    reload_d  = 1'b0;
                end else begin
                    if (sample_edge) begin
                        rx_sr_d = rx_shifted;
                        if (bit_cnt_q == LastBit) begin
                            word_done = 1'b1;
                            bit_cnt_d = '0;
                            reload_d  = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    // With CPHA=1 the first bit is already on MISO when the word starts.
                    if (shift_edge) begin
                        if (reload_q) begin
                            tx_sr_d  = tx_i;
                            reload_d = 1'b0;
                        end else if (cpha_i == CphaLeading || bit_cnt_q != '0) begin
                            tx_sr_d = tx_shifted;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rx_d  = rx_q;
        irq_d = irq_q;
        if (word_done) begin
            rx_d  = rx_shifted;
            irq_d = 1'b1;
        end else if (ack_i) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_q      <= '0;
            irq_q     <= 1'b0;
            reload_q  <= 1'b0;
            miso_q    <= 1'b0;
            miso_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_q      <= rx_d;
            irq_q     <= irq_d;
            reload_q  <= reload_d;
            miso_en_q <= (state_q == StShift);
            if (state_q == StShift) begin
                miso_q <= (dord_i == DordLsbFirst) ? tx_sr_q[0] : tx_sr_q[DATA_W-1];
            end else begin
                miso_q <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic ovr_q, ovr_d;

    always_comb begin
        ovr_d = ovr_q;
        if (word_done && irq_q && !ack_i) begin
            ovr_d = 1'b1;
        end else if (ack_i) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign ovr_o = ovr_q;
`endif

    assign rx_o      = rx_q;
    assign irq_o     = irq_q;
    assign busy_o    = (state_q == StShift);
    assign miso_o    = miso_q;
    assign miso_en_o = miso_en_q;

endmodule
